// File: rtl/cu_microsequencer.sv
// cu_microsequencer -- microprogram sequencer for the control unit.
//
// Holds the control address register (CAR) and computes the next
// micro-address from the control word's sequencing field. It supports
// opcode dispatch (with a one-shot indirect cycle), condition-select
// branching, an optional micro-subroutine return stack, and explicit
// RUN / STEP_WAIT / HALTED states.
//
// Optional feature macro: CU_SEQ_STACK_EN
//   defined   -> CALL/RET use a STACK_DEPTH-entry return stack
//   undefined -> CALL acts as JUMP, RET acts as FETCH, o_sp/o_stack_err = 0
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_cpu_start        enable; low freezes all state and forces o_car to 0
//   i_step_mode        single-instruction stepping
//   i_step_go          pulse releasing the next fetch in step mode
//   i_halt             halt request, sampled on FETCH
//   i_seq_op           sequencing field (HOLD/INC/DISPATCH/FETCH/JUMP/BRANCH/CALL/RET)
//   i_jump_addr        target for JUMP/BRANCH/CALL
//   i_map_addr         dispatch target from the opcode map ROM
//   i_indirect         current instruction needs an indirect cycle
//   i_cond_sel         00 ZF, 01 NF, 10 ZF|NF, 11 MF
//   i_flags            {MF,NF,ZF}
//   o_car              current micro-address (0 while i_cpu_start is low)
//   o_state            00 RUN, 01 STEP_WAIT, 10 HALTED
//   o_sp               return-stack occupancy
//   o_stack_err        sticky overflow/underflow flag
//   o_indirect_done    indirect cycle already taken for this instruction
module cu_microsequencer #(
  parameter int ADDR_W        = 7,
  parameter int STACK_DEPTH   = 4,
  parameter int FETCH_ADDR    = 0,
  parameter int INDIRECT_ADDR = 5
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_cpu_start,
  input  logic                         i_step_mode,
  input  logic                         i_step_go,
  input  logic                         i_halt,
  input  logic [2:0]                   i_seq_op,
  input  logic [ADDR_W-1:0]            i_jump_addr,
  input  logic [ADDR_W-1:0]            i_map_addr,
  input  logic                         i_indirect,
  input  logic [1:0]                   i_cond_sel,
  input  logic [2:0]                   i_flags,
  output logic [ADDR_W-1:0]            o_car,
  output logic [1:0]                   o_state,
  output logic [$clog2(STACK_DEPTH):0] o_sp,
  output logic                         o_stack_err,
  output logic                         o_indirect_done
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  localparam logic [2:0] OP_HOLD     = 3'b000;
  localparam logic [2:0] OP_INC      = 3'b001;
  localparam logic [2:0] OP_DISPATCH = 3'b010;
  localparam logic [2:0] OP_FETCH    = 3'b011;
  localparam logic [2:0] OP_JUMP     = 3'b100;
  localparam logic [2:0] OP_BRANCH   = 3'b101;
  localparam logic [2:0] OP_CALL     = 3'b110;
  localparam logic [2:0] OP_RET      = 3'b111;

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_STEP_WAIT = 2'b01,
    ST_HALTED    = 2'b10
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   car, car_nxt, car_inc;
  logic                ind_done, ind_nxt;
  logic                do_fetch;

  // Flags are {MF,NF,ZF}.
  function automatic logic cond_true(input logic [1:0] sel, input logic [2:0] f);
    case (sel)
      2'b00:   cond_true = f[0];
      2'b01:   cond_true = f[1];
      2'b10:   cond_true = f[0] | f[1];
      default: cond_true = f[2];
    endcase
  endfunction

  assign car_inc = car + 1'b1;

`ifdef CU_SEQ_STACK_EN
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int STK_N = 1 << IDX_W;

  logic [SP_W-1:0]   sp, sp_nxt;
  logic              stack_err, err_nxt;
  logic              push_en;
  logic [ADDR_W-1:0] stack [STK_N];
  logic [IDX_W-1:0]  push_idx, pop_idx;

  assign push_idx = IDX_W'(sp);
  assign pop_idx  = IDX_W'(sp - 1'b1);
`endif

  always_comb begin
    car_nxt   = car;
    state_nxt = state;
    ind_nxt   = ind_done;
    do_fetch  = 1'b0;
`ifdef CU_SEQ_STACK_EN
    sp_nxt    = sp;
    err_nxt   = stack_err;
    push_en   = 1'b0;
`endif
    case (state)
      ST_RUN: begin
        case (i_seq_op)
          OP_HOLD: ;
          OP_INC:  car_nxt = car_inc;
          OP_DISPATCH: begin
            // The indirect cycle is taken at most once per instruction.
            if (i_indirect && !ind_done) begin
              car_nxt = ADDR_W'(INDIRECT_ADDR);
              ind_nxt = 1'b1;
            end else begin
              car_nxt = i_map_addr;
            end
          end
          OP_FETCH: do_fetch = 1'b1;
          OP_JUMP:  car_nxt = i_jump_addr;
          OP_BRANCH: car_nxt = cond_true(i_cond_sel, i_flags) ? i_jump_addr : car_inc;
          OP_CALL: begin
`ifdef CU_SEQ_STACK_EN
            if (sp == SP_W'(STACK_DEPTH)) begin
              car_nxt = car_inc;
              err_nxt = 1'b1;
            end else begin
              push_en = 1'b1;
              sp_nxt  = sp + 1'b1;
              car_nxt = i_jump_addr;
            end
`else
            car_nxt = i_jump_addr;
`endif
          end
          default: begin // OP_RET
`ifdef CU_SEQ_STACK_EN
            if (sp == '0) begin
              err_nxt  = 1'b1;
              do_fetch = 1'b1;
            end else begin
              car_nxt = stack[pop_idx];
              sp_nxt  = sp - 1'b1;
            end
`else
            do_fetch = 1'b1;
`endif
          end
        endcase
        if (do_fetch) begin
          if (i_halt) begin
            state_nxt = ST_HALTED;
          end else if (i_step_mode && !i_step_go) begin
            state_nxt = ST_STEP_WAIT;
          end else begin
            car_nxt = ADDR_W'(FETCH_ADDR);
            ind_nxt = 1'b0;
`ifdef CU_SEQ_STACK_EN
            sp_nxt  = '0;
`endif
          end
        end
      end
      ST_STEP_WAIT: begin
        if (i_step_go) begin
          if (i_halt) begin
            state_nxt = ST_HALTED;
          end else begin
            state_nxt = ST_RUN;
            car_nxt   = ADDR_W'(FETCH_ADDR);
            ind_nxt   = 1'b0;
`ifdef CU_SEQ_STACK_EN
            sp_nxt    = '0;
`endif
          end
        end
      end
      default: ; // HALTED: only reset leaves
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      car      <= ADDR_W'(FETCH_ADDR);
      state    <= ST_RUN;
      ind_done <= 1'b0;
    end else if (i_cpu_start) begin
      car      <= car_nxt;
      state    <= state_nxt;
      ind_done <= ind_nxt;
    end
  end

`ifdef CU_SEQ_STACK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sp        <= '0;
      stack_err <= 1'b0;
      for (int i = 0; i < STK_N; i++) stack[i] <= '0;
    end else if (i_cpu_start) begin
      sp        <= sp_nxt;
      stack_err <= err_nxt;
      if (push_en) stack[push_idx] <= car_inc;
    end
  end

  assign o_sp        = sp;
  assign o_stack_err = stack_err;
`else
  assign o_sp        = '0;
  assign o_stack_err = 1'b0;
`endif

  assign o_car           = i_cpu_start ? car : '0;
  assign o_state         = state;
  assign o_indirect_done = ind_done;

endmodule

// File: tb/tb_cu_microsequencer.sv
// tb_cu_microsequencer -- self-checking bench for cu_microsequencer.
// A behavioural model (integers plus a queue as the return stack) is
// advanced every clock and all outputs are compared one cycle later.
module tb_cu_microsequencer;

  localparam int AW    = 7;
  localparam int DEPTH = 4;
  localparam int FA    = 0;
  localparam int IA    = 5;
  localparam int MASK  = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start, step_mode, step_go, halt, indirect;
  logic [2:0]    seq_op, flags;
  logic [1:0]    cond_sel;
  logic [AW-1:0] jump_addr, map_addr;
  logic [AW-1:0] o_car;
  logic [1:0]    o_state;
  logic [2:0]    o_sp;
  logic          o_stack_err, o_indirect_done;

  int tests = 0;
  int fails = 0;

  // Reference model
  int  m_car;
  int  m_state; // 0 RUN, 1 STEP_WAIT, 2 HALTED
  bit  m_ind;
  bit  m_err;
  int  m_stk[$];

  cu_microsequencer #(.ADDR_W(AW), .STACK_DEPTH(DEPTH), .FETCH_ADDR(FA), .INDIRECT_ADDR(IA)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cpu_start(start), .i_step_mode(step_mode),
    .i_step_go(step_go), .i_halt(halt), .i_seq_op(seq_op), .i_jump_addr(jump_addr),
    .i_map_addr(map_addr), .i_indirect(indirect), .i_cond_sel(cond_sel), .i_flags(flags),
    .o_car(o_car), .o_state(o_state), .o_sp(o_sp), .o_stack_err(o_stack_err),
    .o_indirect_done(o_indirect_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".car"},   32'(o_car),           start ? 32'(m_car) : 32'd0);
    check({tag, ".state"}, 32'(o_state),         32'(m_state));
    check({tag, ".sp"},    32'(o_sp),            32'(m_stk.size()));
    check({tag, ".err"},   32'(o_stack_err),     32'(m_err));
    check({tag, ".ind"},   32'(o_indirect_done), 32'(m_ind));
  endtask

  function automatic bit cond_ok();
    case (cond_sel)
      2'd0:    return flags[0];
      2'd1:    return flags[1];
      2'd2:    return flags[0] | flags[1];
      default: return flags[2];
    endcase
  endfunction

  task automatic restart();
    m_car = FA;
    m_ind = 0;
    m_stk.delete();
  endtask

  task automatic model_fetch();
    if (halt) m_state = 2;
    else if (step_mode && !step_go) m_state = 1;
    else restart();
  endtask

  task automatic model_clock();
    if (start) begin
      if (m_state == 0) begin
        case (seq_op)
          3'd0: ;
          3'd1: m_car = (m_car + 1) & MASK;
          3'd2: if (indirect && !m_ind) begin m_car = IA; m_ind = 1; end
                else m_car = int'(map_addr);
          3'd3: model_fetch();
          3'd4: m_car = int'(jump_addr);
          3'd5: m_car = cond_ok() ? int'(jump_addr) : ((m_car + 1) & MASK);
`ifdef CU_SEQ_STACK_EN
          3'd6: if (m_stk.size() == DEPTH) begin m_car = (m_car + 1) & MASK; m_err = 1; end
                else begin m_stk.push_back((m_car + 1) & MASK); m_car = int'(jump_addr); end
          default: if (m_stk.size() == 0) begin m_err = 1; model_fetch(); end
                   else m_car = m_stk.pop_back();
`else
          3'd6: m_car = int'(jump_addr);
          default: model_fetch();
`endif
        endcase
      end else if (m_state == 1) begin
        if (step_go) begin
          if (halt) m_state = 2;
          else begin restart(); m_state = 0; end
        end
      end
    end
  endtask

  task automatic tick(input string tag);
    model_clock();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic op(input logic [2:0] o, input string tag);
    seq_op = o;
    tick(tag);
  endtask

  task automatic defaults();
    start = 1; step_mode = 0; step_go = 0; halt = 0; indirect = 0;
    seq_op = 3'd0; flags = 3'd0; cond_sel = 2'd0; jump_addr = '0; map_addr = '0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    restart();
    m_state = 0;
    m_err = 0;
    check_all(tag);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    defaults();
    m_car = FA; m_state = 0; m_ind = 0; m_err = 0;
    #12 rst_n = 1'b1;
    #1 check_all("reset");

    // INC sequence and wrap
    op(3'd1, "inc1"); op(3'd1, "inc2"); op(3'd1, "inc3");
    check("inc3_const", 32'(o_car), 32'd3);
    jump_addr = 7'h7F; op(3'd4, "jump127");
    op(3'd1, "inc_wrap");
    check("wrap_const", 32'(o_car), 32'd0);

    // Indirect dispatch once, then map target, then fetch clears
    indirect = 1; map_addr = 7'h0B;
    op(3'd2, "disp_ind");
    check("disp_ind_const", 32'(o_car), 32'h05);
    op(3'd2, "disp_map");
    check("disp_map_const", 32'(o_car), 32'h0B);
    op(3'd3, "fetch_clr");
    check("fetch_ind_const", 32'(o_indirect_done), 32'd0);
    indirect = 0;

    // Branch not taken / taken
    jump_addr = 7'h10; op(3'd4, "jump10");
    cond_sel = 2'b10; flags = 3'b000; jump_addr = 7'h11;
    op(3'd5, "br_nt");
    jump_addr = 7'h20; op(3'd4, "jump20");
    flags = 3'b001; jump_addr = 7'h11;
    op(3'd5, "br_t");
    check("br_t_const", 32'(o_car), 32'h11);

    // Call / return and overflow
    jump_addr = 7'h12; op(3'd4, "jump12");
    jump_addr = 7'h40; op(3'd6, "call40");
    check("call_const", 32'(o_car), 32'h40);
    op(3'd7, "ret");
`ifdef CU_SEQ_STACK_EN
    check("ret_const", 32'(o_car), 32'h13);
`else
    check("ret_const", 32'(o_car), 32'(FA));
`endif
    op(3'd3, "fetch_pre_ovf");
    for (int i = 0; i < 5; i++) begin
      jump_addr = 7'(8'h30 + i);
      op(3'd6, "call_ovf");
    end
    op(3'd7, "ret_after_ovf");

    // Step mode
    step_mode = 1;
    op(3'd3, "step_fetch");
    check("step_state_const", 32'(o_state), 32'd1);
    for (int i = 0; i < 10; i++) begin
      jump_addr = 7'($urandom);
      op(3'($urandom), "step_hold");
    end
    step_go = 1; op(3'd0, "step_go");
    check("step_go_const", 32'(o_state), 32'd0);
    step_go = 0; step_mode = 0;
    step_go = 1; op(3'd1, "go_in_run");
    step_go = 0;

    // Halt
    jump_addr = 7'h33; op(3'd4, "jump33");
    halt = 1; op(3'd3, "halt_fetch");
    halt = 0;
    check("halt_const", 32'(o_state), 32'd2);
    for (int i = 0; i < 5; i++) begin
      jump_addr = 7'($urandom);
      op(3'($urandom), "halted_hold");
    end
    start = 0; #1;
    check("gate_car", 32'(o_car), 32'd0);
    op(3'd1, "halted_nostart");
    start = 1;
    do_reset("halt_reset");

    // Randomised run with periodic mid-stream resets
    for (int n = 0; n < 400; n++) begin
      start     = ($urandom_range(7) != 0);
      step_mode = ($urandom_range(3) == 0);
      step_go   = ($urandom_range(3) == 0);
      halt      = ($urandom_range(39) == 0);
      indirect  = $urandom_range(1);
      cond_sel  = 2'($urandom);
      flags     = 3'($urandom);
      jump_addr = 7'($urandom);
      map_addr  = 7'($urandom);
      op(3'($urandom), "rand");
      if (n % 60 == 59) begin
        start = 1;
        do_reset("rand_reset");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cu_microsequencer.md
# cu_microsequencer

Parametrised microprogram sequencer for the control unit: holds the control address register (CAR) and computes the next micro-address from the control word's sequencing field. It adds to the earlier fixed-width CAR:
- external opcode-to-address mapping
- condition-select branching
- a micro-subroutine stack
- explicit RUN/STEP_WAIT/HALTED states

It sits between the control memory (which supplies the sequencing field and jump target) and the IR/flag registers. Its address output drives the control memory read port.

## Interface
- ADDR_W, 7, micro-address width
- STACK_DEPTH, 4, micro-return stack entries (≥1)
- FETCH_ADDR, 0, fetch-cycle entry address
- INDIRECT_ADDR, 5, indirect-cycle entry address

Ports (reset i_rst_n, asynchronous, active-low; clock i_clk):
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_cpu_start  in  1  enable; low freezes all state and forces o_car to 0
- i_step_mode  in  1  single-instruction stepping
- i_step_go  in  1  one-cycle pulse releasing the next fetch in step mode
- i_halt  in  1  halt request (control bit C23), sampled on FETCH
- i_seq_op  in  3  sequencing field
- i_jump_addr  in  ADDR_W  target for JUMP/BRANCH/CALL
- i_map_addr  in  ADDR_W  dispatch target from opcode map ROM
- i_indirect  in  1  current instruction needs an indirect cycle
- i_cond_sel  in  2  00 ZF, 01 NF, 10 ZF|NF, 11 MF
- i_flags  in  3  {MF,NF,ZF}
- o_car  out  ADDR_W  current micro-address
- o_state  out  2  00 RUN, 01 STEP_WAIT, 10 HALTED
- o_sp  out  $clog2(STACK_DEPTH)+1  stack occupancy
- o_stack_err  out  1  sticky overflow/underflow flag
- o_indirect_done  out  1  indirect cycle already taken for this instruction

## Operation
i_seq_op encodings, acted on in RUN only, when i_cpu_start=1:
- 000 HOLD: CAR unchanged.
- 001 INC: CAR+1, modulo 2^ADDR_W (max value wraps to 0).
- 010 DISPATCH: if i_indirect && !indirect_done, CAR←INDIRECT_ADDR and set indirect_done. Otherwise CAR←i_map_addr.
- 011 FETCH:
  - i_halt=1: go to HALTED, CAR held.
  - Else, i_step_mode=1 and i_step_go=0: go to STEP_WAIT, CAR held.
  - Otherwise: CAR←FETCH_ADDR, clear indirect_done, sp←0.
- 100 JUMP: CAR←i_jump_addr.
- 101 BRANCH: selected condition true → i_jump_addr, else CAR+1.
- 110 CALL: push CAR+1 and CAR←i_jump_addr. If sp==STACK_DEPTH: no push, CAR+1, set o_stack_err.
- 111 RET: pop into CAR. If sp==0: set o_stack_err and behave as FETCH.

States:
- STEP_WAIT: i_seq_op is ignored. i_step_go=1 → CAR←FETCH_ADDR, clear indirect_done, sp←0, go to RUN. i_halt=1 in the same cycle takes priority and goes to HALTED.
- HALTED: exited only by reset.
- o_stack_err: cleared only by reset.

## Timing
- Every update is registered on the i_clk rising edge, so a sequencing op takes effect on o_car the next cycle.
- o_car = i_cpu_start ? CAR : 0. This gating is combinational, zero latency.
- Reset values: CAR=FETCH_ADDR, state=RUN, sp=0, stack contents 0, o_stack_err=0, indirect_done=0.
- Reset asserted mid-instruction or mid-stack takes effect immediately (asynchronous).
- i_step_go arriving in RUN is ignored, not queued.
- CALL/RET ops and push/pop both complete in one cycle. Only one stack operation occurs per cycle.

## Configuration
- CU_SEQ_STACK_EN defined: stack implemented as described.
- CU_SEQ_STACK_EN undefined:
  - CALL behaves as JUMP and RET behaves as FETCH.
  - No stack storage is built; o_sp and o_stack_err are tied to 0.

## Test plan
- Reset, then INC ×3 → o_car 0,1,2,3. With ADDR_W=7 and CAR=127, INC → 0.
- i_indirect=1, DISPATCH twice, i_map_addr=0x0B → o_car 0x05, then 0x0B. A following FETCH → 0x00 and o_indirect_done=0.
- BRANCH with i_cond_sel=10, i_flags=000, CAR=0x10, i_jump_addr=0x11 → 0x11 not taken, so o_car=0x11 via INC path from 0x10. Repeat with flags=001 from 0x20 → 0x11.
- CALL 0x40 from 0x12, then RET → 0x40, then 0x13. Five CALLs with STACK_DEPTH=4 → o_sp=4, o_stack_err=1.
- Step mode: FETCH → o_state=01, o_car held for 10 cycles. i_step_go pulse → o_car=0, o_state=00.
- FETCH with i_halt=1 → o_state=10, o_car frozen. Drop i_cpu_start → o_car=0. Only reset returns to RUN.
